// File: rtl/node_pkg.sv
// node_pkg: constants, state type and address helper shared by the node
// datapath and its upstream feeder.
package node_pkg;

    localparam int N_INPUTS     = 64;
    localparam int DATA_W       = 16;
    localparam int CNT_W        = 7;
    localparam int SEL_W        = 4;
    localparam int DRAIN_CYCLES = 2;

    localparam int IDX_W   = $clog2(N_INPUTS);
    localparam int ADDR_W  = SEL_W + IDX_W;
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [2:0] {
        LOAD     = 3'd0,
        CLEAR    = 3'd1,
        PREFETCH = 3'd2,
        STREAM   = 3'd3,
        DRAIN    = 3'd4,
        DONE     = 3'd5
    } feeder_state_t;

    // Concatenation keeps every index inside its own coefficient set.
    function automatic logic [ADDR_W-1:0] coef_addr_f(
        input logic [SEL_W-1:0] sel,
        input logic [IDX_W-1:0] idx
    );
        return {sel, idx};
    endfunction

endpackage

// File: rtl/node_feeder_buf.sv
// node_feeder_buf: sample RAM for the feeder, one or two banks of N_INPUTS
// words. Registered write, combinational read by index.
module node_feeder_buf
    import node_pkg::*;
#(
    parameter int N_BANKS = 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic              wr_bank,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_bank,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] bank_rd [N_BANKS];

    genvar gi;
    generate
        for (gi = 0; gi < N_BANKS; gi++) begin : g_bank
            logic [DATA_W-1:0] mem [N_INPUTS];
            logic              bank_we;

            assign bank_we = we && ((N_BANKS == 1) || (wr_bank == 1'(gi)));

            // Store the accepted sample into this bank.
            always_ff @(posedge clk) begin
                if (bank_we) begin
                    mem[wr_addr] <= wr_data;
                end
            end

            assign bank_rd[gi] = mem[rd_idx];
        end
    endgenerate

    assign rd_data = ((N_BANKS == 1) || !rd_bank) ? bank_rd[0] : bank_rd[N_BANKS-1];

endmodule

// File: rtl/node_feeder.sv
// node_feeder: buffers one input vector, fetches the node's coefficients
// from a synchronous ROM and streams sample/coefficient pairs into node.
// Optional feature macro: NODE_FEEDER_PING_PONG_EN (two banks, loading
// overlaps streaming).
module node_feeder
    import node_pkg::*;
(
    input  logic              clk,
    input  logic              n_rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [SEL_W-1:0]  node_sel,
    output logic [ADDR_W-1:0] coef_addr,
    input  logic [DATA_W-1:0] coef_rdata,
    output logic              reset_acc,
    output logic              start,
    output logic [CNT_W-1:0]  cnt_val,
    output logic [DATA_W-1:0] coef,
    output logic [DATA_W-1:0] data_out,
    output logic              vec_done,
    output logic              busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);

    feeder_state_t      state_q, state_d;
    logic [IDX_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
    logic [SEL_W-1:0]   node_sel_q, node_sel_d;
    logic [ADDR_W-1:0]  coef_addr_q, coef_addr_d;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic               ready_en_q;

    logic               wr_en;
    logic               wr_last;
    logic               wr_bank;
    logic               rd_bank;
    logic               load_ready;
    logic               next_ready;
    logic [DATA_W-1:0]  rd_data;

    assign wr_en   = in_valid && in_ready;
    assign wr_last = wr_en && (wr_ptr_q == LAST_IDX);

`ifdef NODE_FEEDER_PING_PONG_EN
    localparam int N_BANKS = 2;

    logic       wr_bank_q, wr_bank_d;
    logic       rd_bank_q, rd_bank_d;
    logic [1:0] full_q, full_d;

    assign wr_bank    = wr_bank_q;
    assign rd_bank    = rd_bank_q;
    assign in_ready   = ready_en_q && !full_q[wr_bank_q];
    assign load_ready = full_q[rd_bank_q] || (wr_last && (wr_bank_q == rd_bank_q));
    assign next_ready = full_q[~rd_bank_q] || (wr_last && (wr_bank_q != rd_bank_q));

    // Bank bookkeeping: a bank fills on its last write and frees in DONE.
    always_comb begin
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        full_d    = full_q;
        if (wr_last) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
        end
        if (state_q == DONE) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end
    end

    // Bank pointer and full-flag registers.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            full_q    <= 2'b00;
        end else begin
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            full_q    <= full_d;
        end
    end
`else
    localparam int N_BANKS = 1;

    assign wr_bank    = 1'b0;
    assign rd_bank    = 1'b0;
    assign in_ready   = ready_en_q && (state_q == LOAD);
    assign load_ready = wr_last;
    assign next_ready = 1'b0;
`endif

    node_feeder_buf #(
        .N_BANKS (N_BANKS)
    ) u_buf (
        .clk     (clk),
        .we      (wr_en),
        .wr_bank (wr_bank),
        .wr_addr (wr_ptr_q),
        .wr_data (in_data),
        .rd_bank (rd_bank),
        .rd_idx  (rd_idx_q),
        .rd_data (rd_data)
    );

    // Sequencer next-state: the ROM address register runs one index ahead of
    // rd_idx so that coef_rdata lines up with the step being streamed.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_idx_d    = rd_idx_q;
        node_sel_d  = node_sel_q;
        coef_addr_d = coef_addr_q;
        drain_cnt_d = drain_cnt_q;

        if (wr_en) begin
            wr_ptr_d = wr_last ? '0 : wr_ptr_q + 1'b1;
        end

        unique case (state_q)
            LOAD: begin
                if (load_ready) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                node_sel_d  = node_sel;
                coef_addr_d = coef_addr_f(node_sel, '0);
                rd_idx_d    = '0;
                state_d     = PREFETCH;
            end
            PREFETCH: begin
                coef_addr_d = coef_addr_f(node_sel_q, IDX_W'(1));
                state_d     = STREAM;
            end
            STREAM: begin
                // Stop advancing once the last index is addressed.
                if (rd_idx_q < (LAST_IDX - 1'b1)) begin
                    coef_addr_d = coef_addr_f(node_sel_q, rd_idx_q + IDX_W'(2));
                end
                if (rd_idx_q == LAST_IDX) begin
                    rd_idx_d    = '0;
                    drain_cnt_d = '0;
                    state_d     = DRAIN;
                end else begin
                    rd_idx_d = rd_idx_q + 1'b1;
                end
            end
            DRAIN: begin
                if (drain_cnt_q == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                    state_d = DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = next_ready ? CLEAR : LOAD;
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // Sequencer registers; ready_en_q holds in_ready low through reset.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q     <= LOAD;
            wr_ptr_q    <= '0;
            rd_idx_q    <= '0;
            node_sel_q  <= '0;
            coef_addr_q <= '0;
            drain_cnt_q <= '0;
            ready_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_idx_q    <= rd_idx_d;
            node_sel_q  <= node_sel_d;
            coef_addr_q <= coef_addr_d;
            drain_cnt_q <= drain_cnt_d;
            ready_en_q  <= 1'b1;
        end
    end

    assign coef_addr = coef_addr_q;
    assign reset_acc = (state_q == CLEAR);
    assign start     = (state_q == STREAM);
    assign cnt_val   = start ? CNT_W'(rd_idx_q) : '0;
    assign coef      = start ? coef_rdata : '0;
    assign data_out  = start ? rd_data : '0;
    assign vec_done  = (state_q == DONE);
    assign busy      = (state_q != LOAD);

endmodule

// File: tb/tb_node_feeder.sv
// tb_node_feeder: table-driven and randomized vectors for node_feeder,
// checked every cycle against a phase-count reference model.
module tb_node_feeder;
    import node_pkg::*;

    logic              clk = 1'b0;
    logic              n_rst = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic [SEL_W-1:0]  node_sel = '0;
    logic [ADDR_W-1:0] coef_addr;
    logic [DATA_W-1:0] coef_rdata;
    logic              reset_acc;
    logic              start;
    logic [CNT_W-1:0]  cnt_val;
    logic [DATA_W-1:0] coef;
    logic [DATA_W-1:0] data_out;
    logic              vec_done;
    logic              busy;

    node_feeder dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .node_sel   (node_sel),
        .coef_addr  (coef_addr),
        .coef_rdata (coef_rdata),
        .reset_acc  (reset_acc),
        .start      (start),
        .cnt_val    (cnt_val),
        .coef       (coef),
        .data_out   (data_out),
        .vec_done   (vec_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Synchronous ROM with ROM[a] = a and one cycle of read latency.
    always @(posedge clk) coef_rdata <= DATA_W'(coef_addr);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: phase 0 = loading, 1..69 = cycles after the 64th accept
    // (1 clear, 2 prefetch, 3..66 stream steps 0..63, 67..68 drain, 69 done).
    int                phase = 0;
    int                cnt = 0;
    bit                rdy_en = 1'b0;
    int                sel_lat = 0;
    int                acc_cyc = 0;
    logic [DATA_W-1:0] samp [N_INPUTS];
    int                first_coef_seen = -1;
    int                first_data_seen = -1;
    int                last_addr_seen = -1;

    // Compare outputs against the model, then advance the model.
    always @(negedge clk) begin
        int k;
        bit st;
        bit exp_rdy;
        st      = (phase >= 3) && (phase <= 66);
        k       = phase - 3;
        exp_rdy = rdy_en && (phase == 0);
        chk("in_ready", in_ready, exp_rdy);
        chk("reset_acc", reset_acc, phase == 1);
        chk("start", start, st);
        chk("vec_done", vec_done, phase == 69);
        chk("busy", busy, phase != 0);
        if (st) begin
            chk("cnt_val", cnt_val, k);
            chk("coef", coef, sel_lat * 64 + k);
            chk("data_out", data_out, samp[k]);
            chk("coef_addr", coef_addr, sel_lat * 64 + ((k < 63) ? k + 1 : 63));
        end else begin
            chk("cnt_val idle", cnt_val, 0);
            chk("coef idle", coef, 0);
            chk("data_out idle", data_out, 0);
        end
        if (phase == 2) chk("coef_addr prefetch", coef_addr, sel_lat * 64);

        if (start && cnt_val == 0) begin
            first_coef_seen = int'(coef);
            first_data_seen = int'(data_out);
        end
        if (start && cnt_val == 7'd63) last_addr_seen = int'(coef_addr);

        if (!n_rst) begin
            phase  = 0;
            cnt    = 0;
            rdy_en = 1'b0;
        end else begin
            if (phase == 0) begin
                if (in_valid && exp_rdy) begin
                    samp[cnt] = in_data;
                    cnt++;
                    if (cnt == N_INPUTS) begin
                        cnt     = 0;
                        phase   = 1;
                        acc_cyc = cyc;
                    end
                end
            end else if (phase == 1) begin
                sel_lat = int'(node_sel);
                phase   = 2;
            end else if (phase == 69) begin
                phase = 0;
            end else begin
                phase++;
            end
            rdy_en = 1'b1;
        end
    end

    // Present 64 samples; gap 0 = continuous, 1 = toggling, 2 = random.
    task automatic send_vec(input int sel, input int gap, input bit hold, input int base, input bit rnd);
        int sent = 0;
        int guard = 0;
        bit acc;
        node_sel = SEL_W'(sel);
        while (sent < N_INPUTS && guard < 1000) begin
            case (gap)
                0:       in_valid = 1'b1;
                1:       in_valid = (guard % 2) == 0;
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_data = rnd ? DATA_W'($urandom) : DATA_W'(base + sent);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) sent++;
            guard++;
        end
        if (sent < N_INPUTS) chk("load timeout", sent, N_INPUTS);
        in_valid = hold;
        in_data  = 16'hDEAD;
    endtask

    task automatic wait_done(output int lat);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 300) begin
            @(negedge clk);
            seen = vec_done;
            n++;
            if (n == 3) node_sel = SEL_W'($urandom);
        end
        lat = cyc - acc_cyc;
        chk("vec_done seen", seen, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    typedef struct {
        int sel;
        int gap;
        bit hold;
        int base;
        int exp_first_coef;
        int exp_first_data;
        int exp_last_addr;
        int exp_lat;
    } vec_t;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [5];
        int lat;
        tbl[0] = '{sel: 3,  gap: 0, hold: 0, base: 16'h0001, exp_first_coef: 192,
                   exp_first_data: 16'h0001, exp_last_addr: 255,  exp_lat: 69};
        tbl[1] = '{sel: 0,  gap: 1, hold: 0, base: 16'h0100, exp_first_coef: 0,
                   exp_first_data: 16'h0100, exp_last_addr: 63,   exp_lat: 69};
        tbl[2] = '{sel: 15, gap: 0, hold: 1, base: 16'h8000, exp_first_coef: 960,
                   exp_first_data: 16'h8000, exp_last_addr: 1023, exp_lat: 69};
        tbl[3] = '{sel: 7,  gap: 2, hold: 1, base: 16'hFFC0, exp_first_coef: 448,
                   exp_first_data: 16'hFFC0, exp_last_addr: 511,  exp_lat: 69};
        tbl[4] = '{sel: 15, gap: 2, hold: 0, base: 16'h0A00, exp_first_coef: 960,
                   exp_first_data: 16'h0A00, exp_last_addr: 1023, exp_lat: 69};

        repeat (3) @(posedge clk);
        #1 n_rst = 1'b1;

        for (int i = 0; i < 5; i++) begin
            send_vec(tbl[i].sel, tbl[i].gap, tbl[i].hold, tbl[i].base, 1'b0);
            wait_done(lat);
            chk("first coef", first_coef_seen, tbl[i].exp_first_coef);
            chk("first data", first_data_seen, tbl[i].exp_first_data);
            chk("last coef_addr", last_addr_seen, tbl[i].exp_last_addr);
            chk("accept-to-done latency", lat, tbl[i].exp_lat);
            $display("table vec %0d: sel=%0d gap=%0d hold=%0d lat=%0d first_coef=%0d last_addr=%0d",
                     i, tbl[i].sel, tbl[i].gap, tbl[i].hold, lat, first_coef_seen, last_addr_seen);
        end

        for (int i = 0; i < 6; i++) begin
            int sel;
            int gap;
            bit hold;
            sel  = int'($urandom_range(0, 15));
            gap  = int'($urandom_range(0, 2));
            hold = 1'($urandom_range(0, 1));
            send_vec(sel, gap, hold, 0, 1'b1);
            wait_done(lat);
            chk("random latency", lat, 69);
            $display("random vec %0d: sel=%0d gap=%0d hold=%0d lat=%0d", i, sel, gap, hold, lat);
        end

        // Reset in the middle of STREAM: abort, outputs cleared, no vec_done.
        send_vec(5, 0, 1'b0, 16'h0300, 1'b0);
        repeat (20) @(posedge clk);
        #1 n_rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 n_rst = 1'b1;
        @(negedge clk);
        chk("rst start", start, 0);
        chk("rst reset_acc", reset_acc, 0);
        chk("rst in_ready", in_ready, 0);
        chk("rst busy", busy, 0);
        chk("rst vec_done", vec_done, 0);
        chk("rst coef_addr", coef_addr, 0);
        chk("rst cnt_val", cnt_val, 0);
        @(negedge clk);
        chk("in_ready after release", in_ready, 1);
        $display("reset mid-stream: in_ready=%0d busy=%0d", in_ready, busy);
        @(posedge clk);
        #1;

        send_vec(9, 2, 1'b1, 0, 1'b1);
        wait_done(lat);
        chk("post-reset latency", lat, 69);
        $display("post-reset vec: sel=9 lat=%0d", lat);

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
